// File: rtl/csd2bin_sched.sv
// Round-robin scheduler that shares one combinational CSD-to-binary converter
// between two requesters and registers the result behind a valid/ready port.

module csd2bin #(
  parameter int W = 5
) (
  input  logic [2*W-1:0] x,
  output logic [W-1:0]   y,
  output logic           err
);

  logic [W-1:0] pos;
  logic [W-1:0] neg;
  logic [W-1:0] ill;

  // Split the word into +1 and -1 bit masks; illegal digits land in neither.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_digit
      assign pos[gi] = (x[2*gi +: 2] == 2'b01);
      assign neg[gi] = (x[2*gi +: 2] == 2'b10);
      assign ill[gi] = (x[2*gi +: 2] == 2'b11);
    end
  endgenerate

  assign y   = pos - neg;
  assign err = |ill;

endmodule

module csd2bin_sched #(
  parameter int W        = 5,
  parameter int CNT_SIZE = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic [2*W-1:0]      req0_x,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [2*W-1:0]      req1_x,
  output logic                req1_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_y,
  output logic                out_id,
  output logic                out_err,
  output logic [CNT_SIZE-1:0] conv_cnt
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [W-1:0]        y_q, y_d;
  logic                id_q, id_d;
  logic                err_q, err_d;
  logic [CNT_SIZE-1:0] cnt_q, cnt_d;

  logic           grant0;
  logic           grant1;
  logic           acc_en;
  logic           accept;
  logic           transfer;
  logic           sel_id;
  logic [2*W-1:0] sel_x;
  logic [W-1:0]   conv_y;
  logic           conv_err;

  // Contention goes to whichever requester was not served last.
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  assign acc_en     = rst_n & ((state_q == S_EMPTY) | out_ready);
  assign req0_ready = acc_en & grant0;
  assign req1_ready = acc_en & grant1;
  assign accept     = req0_ready | req1_ready;
  assign transfer   = (state_q == S_FULL) & out_ready;

  assign sel_id = req1_ready;
  assign sel_x  = req1_ready ? req1_x : req0_x;

  csd2bin #(
    .W(W)
  ) u_csd2bin (
    .x  (sel_x),
    .y  (conv_y),
    .err(conv_err)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    y_d     = y_q;
    id_d    = id_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (out_ready && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase

    if (accept) begin
      y_d    = conv_y;
      id_d   = sel_id;
      err_d  = conv_err;
      last_d = sel_id;
    end

    if (transfer) begin
      cnt_d = cnt_q + {{(CNT_SIZE-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      last_q  <= 1'b1;
      y_q     <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      y_q     <= y_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_y     = y_q;
  assign out_id    = id_q;
  assign out_err   = err_q;
  assign conv_cnt  = cnt_q;

endmodule

// File: tb/tb_csd2bin_sched.sv
// Bench for csd2bin_sched: directed scenario tasks plus a background scoreboard
// that predicts every accept, transfer and held result from a reference model.
`timescale 1ns/1ps

module tb_csd2bin_sched;

  localparam int W  = 5;
  localparam int CS = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [2*W-1:0] req0_x, req1_x;
  logic          req0_ready, req1_ready;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_y;
  logic          out_id, out_err;
  logic [CS-1:0] conv_cnt;

  int checks   = 0;
  int failures = 0;

  logic [6:0] sb_q[$];   // {id, err, y}

  always #5 clk = ~clk;

  csd2bin_sched #(.W(W), .CNT_SIZE(CS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_x    (req0_x),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_x    (req1_x),
    .req1_ready(req1_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id),
    .out_err   (out_err),
    .conv_cnt  (conv_cnt)
  );

  // Reference conversion: signed integer sum of digit weights, then truncation.
  function automatic logic [6:0] model(input logic [2*W-1:0] x, input logic id);
    int          s;
    logic        e;
    logic [31:0] t;
    logic [1:0]  d;
    s = 0;
    e = 1'b0;
    for (int i = 0; i < W; i++) begin
      d = x[2*i +: 2];
      if (d == 2'b01) s = s + (1 << i);
      else if (d == 2'b10) s = s - (1 << i);
      else if (d == 2'b11) e = 1'b1;
    end
    t = s;
    return {id, e, t[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scoreboard_monitor();
    logic       exp_full = 1'b0;
    logic       exp_last = 1'b1;
    logic [CS-1:0] exp_cnt = '0;
    logic       held = 1'b0;
    logic [6:0] held_val = '0;
    logic       g0, g1, en;
    logic [6:0] v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        exp_full = 1'b0;
        exp_last = 1'b1;
        exp_cnt  = '0;
        held     = 1'b0;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          failures++;
          $display("FAIL sb_reset_ready: got r0=%b r1=%b required 0 0", req0_ready, req1_ready);
        end
      end else begin
        checks++;
        if (out_valid !== exp_full) begin
          failures++;
          $display("FAIL sb_out_valid: got %b required %b", out_valid, exp_full);
        end
        checks++;
        if (conv_cnt !== exp_cnt) begin
          failures++;
          $display("FAIL sb_conv_cnt: got %0d required %0d", conv_cnt, exp_cnt);
        end
        if (held) begin
          checks++;
          if ({out_id, out_err, out_y} !== held_val) begin
            failures++;
            $display("FAIL sb_hold: got %h required %h", {out_id, out_err, out_y}, held_val);
          end
        end
        g0 = req0_valid && (!req1_valid || exp_last);
        g1 = req1_valid && (!req0_valid || !exp_last);
        en = !exp_full || out_ready;
        checks++;
        if (req0_ready !== (en && g0) || req1_ready !== (en && g1)) begin
          failures++;
          $display("FAIL sb_ready: got r0=%b r1=%b required r0=%b r1=%b",
                   req0_ready, req1_ready, en && g0, en && g1);
        end
        if (exp_full && out_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow: got transfer required empty queue entry");
          end else begin
            v = sb_q.pop_front();
            if ({out_id, out_err, out_y} !== v) begin
              failures++;
              $display("FAIL sb_result: got id=%b err=%b y=%b required id=%b err=%b y=%b",
                       out_id, out_err, out_y, v[6], v[5], v[4:0]);
            end
          end
          exp_cnt = exp_cnt + 1'b1;
        end
        held     = exp_full && !out_ready;
        held_val = {out_id, out_err, out_y};
        if (en && (g0 || g1)) begin
          sb_q.push_back(model(g1 ? req1_x : req0_x, g1));
          exp_last = g1;
        end
        exp_full = (en && (g0 || g1)) || (exp_full && !out_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = 10'b0100000010; req1_x = 10'b1000000000;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready);
    end
    checks++;
    if ({out_valid, out_id, out_err, out_y, conv_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state: got v=%b id=%b err=%b y=%b cnt=%0d required all 0",
               out_valid, out_id, out_err, out_y, conv_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 10'b0100000010;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready: got r0=%b r1=%b required 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_y !== 5'b01111 || out_id !== 1'b0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL single_result: got v=%b y=%b id=%b err=%b required 1 01111 0 0",
               out_valid, out_y, out_id, out_err);
    end
    $display("single: x=%b y=%b id=%b", 10'b0100000010, out_y, out_id);
    tick();
  endtask

  task automatic test_req1();
    logic [2*W-1:0] xs[2];
    logic [W-1:0]   ys[2];
    xs[0] = 10'b1000000000; ys[0] = 5'b10000;
    xs[1] = 10'b0101010101; ys[1] = 5'b11111;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req1_valid = 1'b1; req1_x = xs[k];
      @(negedge clk);
      checks++;
      if (req1_ready !== 1'b1) begin
        failures++;
        $display("FAIL req1_ready: got %b required 1", req1_ready);
      end
      @(posedge clk); #1;
      req1_valid = 1'b0;
      checks++;
      if (out_y !== ys[k] || out_id !== 1'b1 || out_err !== 1'b0) begin
        failures++;
        $display("FAIL req1_result: got y=%b id=%b err=%b required y=%b id=1 err=0",
                 out_y, out_id, out_err, ys[k]);
      end
      $display("req1: x=%b y=%b id=%b", xs[k], out_y, out_id);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [2*W-1:0] xs[2];
    logic [W-1:0]   ys[2];
    xs[0] = 10'b0000000011; ys[0] = 5'b00000;
    xs[1] = 10'b1100000001; ys[1] = 5'b00001;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req0_valid = 1'b1; req0_x = xs[k];
      tick();
      req0_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_err !== 1'b1 || out_y !== ys[k]) begin
        failures++;
        $display("FAIL illegal_result: got v=%b err=%b y=%b required 1 1 %b",
                 out_valid, out_err, out_y, ys[k]);
      end
      $display("illegal: x=%b y=%b err=%b", xs[k], out_y, out_err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n0 = 0;
    int n1 = 0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 10'b0000000101;
    req1_valid = 1'b1; req1_x = 10'b0010100000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (req0_ready === 1'b1) n0++;
      if (req1_ready === 1'b1) n1++;
      @(posedge clk); #1;
      checks++;
      if (out_id !== k[0]) begin
        failures++;
        $display("FAIL rr_id: cycle %0d got %b required %b", k, out_id, k[0]);
      end
      $display("rr: cycle %0d id=%b y=%b", k, out_id, out_y);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    checks++;
    if (conv_cnt !== 5'd4 || n0 != 2 || n1 != 2) begin
      failures++;
      $display("FAIL rr_count: got cnt=%0d acc0=%0d acc1=%0d required 4 2 2", conv_cnt, n0, n1);
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 10'b0100000010;
    req1_valid = 1'b1; req1_x = 10'b1000000000;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_first: got r0=%b r1=%b required 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_y !== 5'b01111 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_stall: got r0=%b r1=%b v=%b y=%b required 0 0 1 01111",
                 req0_ready, req1_ready, out_valid, out_y);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: got r0=%b r1=%b required 0 1", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_id !== 1'b1 || out_y !== 5'b10000) begin
      failures++;
      $display("FAIL hold_next: got v=%b id=%b y=%b required 1 1 10000", out_valid, out_id, out_y);
    end
    $display("hold: drained and replaced, y=%b id=%b", out_y, out_id);
    tick();
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    out_ready = 1'b1;
    req0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_x = 10'($urandom);
      tick();
    end
    req0_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || conv_cnt !== 5'd3) begin
      failures++;
      $display("FAIL mid_pre: got v=%b cnt=%0d required 1 3", out_valid, conv_cnt);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || conv_cnt !== 5'd0 || out_y !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset: got v=%b cnt=%0d y=%b required 0 0 00000", out_valid, conv_cnt, out_y);
    end
    $display("reset_mid: cleared");
    out_ready = 1'b1;
    req0_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      req0_x = 10'($urandom);
      tick();
    end
    req0_valid = 1'b0;
    checks++;
    if (conv_cnt !== 5'd31) begin
      failures++;
      $display("FAIL wrap_pre: got %0d required 31", conv_cnt);
    end
    tick();
    checks++;
    if (conv_cnt !== 5'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap: got cnt=%0d v=%b required 0 0", conv_cnt, out_valid);
    end
    $display("wrap: conv_cnt=%0d after 32 transfers", conv_cnt);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req1_x = '0;
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_single();
    test_req1();
    test_illegal();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d entries required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csd2bin_sched.md
# csd2bin_sched

Shared-resource scheduler for the CSD-to-binary converter in the BKM FPU. Two requesters, e.g. the exponent and logarithm iteration stages, each present a W-digit canonical-signed-digit (CSD) word. The block round-robin arbitrates between them and drives one internal combinational `csd2bin` instance. It registers the binary result with a requester tag and an illegal-digit flag behind a valid/ready handshake.

## Interface
- `W`, 5, number of CSD digits and result width in bits.
- `CNT_SIZE`, 5, width of the completed-conversion counter.
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low; sampled only on the rising edge of `clk`.
- `req0_valid` in 1: requester 0 holds a word to convert.
- `req0_x` in 2W: requester 0 CSD word; digit i is `x[2i+1:2i]`.
- `req0_ready` out 1: requester 0 word accepted this cycle.
- `req1_valid`, `req1_x`, `req1_ready`: same three signals for requester 1.
- `out_valid` out 1: result register holds a result.
- `out_ready` in 1: consumer accepts the result.
- `out_y` out W: binary result.
- `out_id` out 1: index of the requester that produced `out_y`.
- `out_err` out 1: at least one illegal digit in the source word.
- `conv_cnt` out CNT_SIZE: number of completed transfers on the output port.

## Operation
- Digit encoding: 00 = 0, 01 = +1, 10 = −1, 11 = illegal.
- Result: `y = Σ d_i·2^i` mod 2^W, two's complement W bits.
  - Illegal digits contribute 0.
  - `out_err` = OR over all digits of (digit == 11).
- Result register FSM, two states:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- Transitions:
  - EMPTY→FULL on any accept.
  - FULL→EMPTY on `out_ready` with no accept in the same cycle.
  - FULL→FULL on `out_ready` with an accept (back-to-back), or when `out_ready` = 0 (hold).
- Accept-enable `acc_en` = EMPTY | `out_ready`.
  - `reqN_ready` is combinational: `acc_en & grantN`.
  - Ready never depends on the same requester's own `reqN_valid` except through the grant.
- Arbitration, round-robin with a 1-bit `last` pointer:
  - Only one requester valid: that one is granted.
  - Both valid: grant `!last`.
  - `last` updates to the granted index only on an accept.
  - No grant asserts when neither requester is valid.
  - At most one `reqN_ready` is high per cycle.
- On accept: the granted word passes through `csd2bin`; `y`, `id` and `err` are loaded into the result register.
- Holding: while FULL and `out_ready` = 0, `out_y`, `out_id` and `out_err` stay stable.
- Counter: `conv_cnt` increments by 1 on each `out_valid & out_ready` and wraps modulo 2^CNT_SIZE.
- Reset (`rst_n` = 0 at a clock edge), including mid-operation: any pending result is discarded and not counted. The block returns to:
  - FSM EMPTY, `out_valid` = 0.
  - `out_y` = 0, `out_id` = 0, `out_err` = 0.
  - `conv_cnt` = 0.
  - `last` = 1, so requester 0 wins the first contention.
  - `reqN_ready` = 0 while `rst_n` = 0.

## Timing
- Latency: a word accepted at edge k gives `out_valid` = 1 with its result after edge k.
- Throughput: one conversion per cycle while `out_ready` stays high.
- Combinational paths:
  - `out_ready` → `reqN_ready`.
  - `reqN_valid` → `reqM_ready`, through the arbiter.
  - No combinational path from `reqN_x` to any output.
- Requesters must hold `reqN_valid` and `reqN_x` stable until `reqN_ready`; the block does not check this.
- Simultaneous accept and drain in one cycle: the new result replaces the old at the edge; `conv_cnt` increments once.

## Test plan
- Reset, then request 0 only with x = 10'b0100000010 (+1,0,0,0,−1) → `req0_ready` = 1 in that cycle. Next cycle `out_valid` = 1, `out_y` = 01111, `out_id` = 0, `out_err` = 0.
- Request 1 with x = 10'b1000000000 (−16) → `out_y` = 10000, `out_id` = 1. Then x = 10'b0101010101 → `out_y` = 11111.
- Both requesters valid for 4 cycles with `out_ready` = 1 → `out_id` sequence 0,1,0,1. `conv_cnt` reaches 4 and each word is accepted exactly once.
- Hold `out_ready` = 0 with both valid → after the first accept both readies stay low and `out_y` is stable. Raising `out_ready` drains the held result and accepts the next in the same cycle.
- Illegal word x = 10'b0000000011 → `out_err` = 1, `out_y` = 00000. Mixed x = 10'b1100000001 → `out_err` = 1, `out_y` = 00001.
- Assert `rst_n` = 0 while FULL with `conv_cnt` = 3 → next cycle `out_valid` = 0, `conv_cnt` = 0, `out_y` = 0. Then 32 consecutive transfers → `conv_cnt` wraps to 0.
